// File: rtl/fxu_reservation_station.sv
// Reservation station for one fixed-point unit. It is a collapsing queue: slot 0 is
// the oldest entry, missing operands are captured from the CDB, and the oldest ready entry issues.
module fxu_reservation_station #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int TW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_instr_valid,
    input  logic [TW-1:0] in_rob_idx,
    input  logic [3:0]    in_opcode,
    input  logic [7:0]    in_i,
    input  logic          in_a_valid,
    input  logic          in_b_valid,
    input  logic [DW-1:0] in_a_value,
    input  logic [DW-1:0] in_b_value,
    input  logic [TW-1:0] in_a_owner,
    input  logic [TW-1:0] in_b_owner,
    output logic          full,
    input  logic          cdb_valid,
    input  logic [TW-1:0] cdb_tag,
    input  logic [DW-1:0] cdb_value,
    input  logic          flush,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [TW-1:0] issue_rob_idx,
    output logic [3:0]    issue_opcode,
    output logic [7:0]    issue_i,
    output logic [DW-1:0] issue_a,
    output logic [DW-1:0] issue_b
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic          busy;
        logic [TW-1:0] rob_idx;
        logic [3:0]    opcode;
        logic [7:0]    imm;
        logic          a_rdy;
        logic [DW-1:0] a_val;
        logic [TW-1:0] a_tag;
        logic          b_rdy;
        logic [DW-1:0] b_val;
        logic [TW-1:0] b_tag;
    } entry_t;

    entry_t          ent   [DEPTH];
    entry_t          nxt   [DEPTH];
    entry_t          woken [DEPTH+1];
    entry_t          new_ent;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   append_pos;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic            accept;
    logic            remove;

    assign full   = (count == CW'(DEPTH));
    assign accept = in_instr_valid & ~full & ~flush;
    assign remove = sel_found & issue_ready;

    // woken[DEPTH] stays empty so the shift below can always read slot i+1
    always_comb begin
        for (int i = 0; i <= DEPTH; i++) woken[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = ent[i];
            if (cdb_valid && ent[i].busy) begin
                if (!ent[i].a_rdy && ent[i].a_tag == cdb_tag) begin
                    woken[i].a_rdy = 1'b1;
                    woken[i].a_val = cdb_value;
                end
                if (!ent[i].b_rdy && ent[i].b_tag == cdb_tag) begin
                    woken[i].b_rdy = 1'b1;
                    woken[i].b_val = cdb_value;
                end
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent[i].busy && ent[i].a_rdy && ent[i].b_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // Operands still owned by a producer can be satisfied by the CDB in the dispatch cycle
    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.rob_idx = in_rob_idx;
        new_ent.opcode  = in_opcode;
        new_ent.imm     = in_i;
        new_ent.a_tag   = in_a_owner;
        new_ent.b_tag   = in_b_owner;
        if (in_a_valid) begin
            new_ent.a_rdy = 1'b1;
            new_ent.a_val = in_a_value;
        end else if (cdb_valid && in_a_owner == cdb_tag) begin
            new_ent.a_rdy = 1'b1;
            new_ent.a_val = cdb_value;
        end
        if (in_b_valid) begin
            new_ent.b_rdy = 1'b1;
            new_ent.b_val = in_b_value;
        end else if (cdb_valid && in_b_owner == cdb_tag) begin
            new_ent.b_rdy = 1'b1;
            new_ent.b_val = cdb_value;
        end
    end

    always_comb begin
        append_pos = count - CW'(remove);
        for (int i = 0; i < DEPTH; i++) begin
            if (remove && i >= int'(sel_idx)) nxt[i] = woken[i+1];
            else                              nxt[i] = woken[i];
            if (accept && CW'(i) == append_pos) nxt[i] = new_ent;
            if (flush) nxt[i] = '0;
        end
        count_nxt = flush ? '0 : count + CW'(accept) - CW'(remove);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) ent[i] <= nxt[i];
        end
    end

    always_comb begin
        issue_valid   = sel_found;
        issue_rob_idx = '0;
        issue_opcode  = '0;
        issue_i       = '0;
        issue_a       = '0;
        issue_b       = '0;
        if (sel_found) begin
            issue_rob_idx = ent[sel_idx].rob_idx;
            issue_opcode  = ent[sel_idx].opcode;
            issue_i       = ent[sel_idx].imm;
            issue_a       = ent[sel_idx].a_val;
            issue_b       = ent[sel_idx].b_val;
        end
    end
endmodule

// File: tb/tb_fxu_reservation_station.sv
// Directed bench for fxu_reservation_station: inputs change and outputs are checked on the
// falling edge, and every expected value is written out by hand.
module tb_fxu_reservation_station;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_instr_valid;
    logic [3:0]  in_rob_idx;
    logic [3:0]  in_opcode;
    logic [7:0]  in_i;
    logic        in_a_valid, in_b_valid;
    logic [15:0] in_a_value, in_b_value;
    logic [3:0]  in_a_owner, in_b_owner;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_rob_idx;
    logic [3:0]  issue_opcode;
    logic [7:0]  issue_i;
    logic [15:0] issue_a, issue_b;

    int vectors = 0;
    int miscompares = 0;

    fxu_reservation_station #(.DEPTH(4), .DW(16), .TW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_instr_valid(in_instr_valid), .in_rob_idx(in_rob_idx),
        .in_opcode(in_opcode), .in_i(in_i),
        .in_a_valid(in_a_valid), .in_b_valid(in_b_valid),
        .in_a_value(in_a_value), .in_b_value(in_b_value),
        .in_a_owner(in_a_owner), .in_b_owner(in_b_owner),
        .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rob_idx(issue_rob_idx), .issue_opcode(issue_opcode),
        .issue_i(issue_i), .issue_a(issue_a), .issue_b(issue_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_instr_valid = 1'b0;
        in_rob_idx = '0; in_opcode = '0; in_i = '0;
        in_a_valid = 1'b0; in_b_valid = 1'b0;
        in_a_value = '0; in_b_value = '0;
        in_a_owner = '0; in_b_owner = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        flush = 1'b0;
    endtask

    // An operand with valid=0 takes its owner tag from the low bits of the argument
    task automatic disp(input logic [3:0] rob, input logic [3:0] op, input logic [7:0] imm,
                        input logic av, input logic [15:0] a,
                        input logic bv, input logic [15:0] b);
        in_instr_valid = 1'b1;
        in_rob_idx = rob; in_opcode = op; in_i = imm;
        in_a_valid = av; in_a_value = av ? a : 16'hDEAD; in_a_owner = a[3:0];
        in_b_valid = bv; in_b_value = bv ? b : 16'hDEAD; in_b_owner = b[3:0];
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [15:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
    endtask

    initial begin
        idle();
        issue_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_issue_valid", 32'(issue_valid), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_issue_a", 32'(issue_a), 32'd0);
        chk("reset_issue_rob", 32'(issue_rob_idx), 32'd0);
        rst_n = 1'b1;

        // basic issue, one-cycle latency
        issue_ready = 1'b1;
        disp(4'd3, 4'd0, 8'h00, 1'b1, 16'h0005, 1'b1, 16'h0007);
        step(); idle();
        chk("basic_valid", 32'(issue_valid), 32'd1);
        chk("basic_rob", 32'(issue_rob_idx), 32'd3);
        chk("basic_a", 32'(issue_a), 32'h5);
        chk("basic_b", 32'(issue_b), 32'h7);
        chk("basic_full", 32'(full), 32'd0);
        step();
        chk("basic_gone", 32'(issue_valid), 32'd0);

        // wakeup from CDB two cycles after dispatch
        disp(4'd4, 4'd1, 8'h00, 1'b0, 16'h0002, 1'b1, 16'h0011);
        step(); idle();
        chk("wake_wait0", 32'(issue_valid), 32'd0);
        step();
        chk("wake_wait1", 32'(issue_valid), 32'd0);
        cdb(4'd2, 16'h1234);
        step(); idle();
        chk("wake_valid", 32'(issue_valid), 32'd1);
        chk("wake_rob", 32'(issue_rob_idx), 32'd4);
        chk("wake_a", 32'(issue_a), 32'h1234);
        chk("wake_b", 32'(issue_b), 32'h0011);
        step();
        chk("wake_gone", 32'(issue_valid), 32'd0);

        // dispatch bypass from the CDB in the same cycle
        disp(4'd6, 4'd5, 8'h3C, 1'b1, 16'h0001, 1'b0, 16'h0009);
        cdb(4'd9, 16'hBEEF);
        step(); idle();
        chk("byp_valid", 32'(issue_valid), 32'd1);
        chk("byp_rob", 32'(issue_rob_idx), 32'd6);
        chk("byp_b", 32'(issue_b), 32'hBEEF);
        chk("byp_opcode", 32'(issue_opcode), 32'd5);
        chk("byp_imm", 32'(issue_i), 32'h3C);
        step();
        chk("byp_gone", 32'(issue_valid), 32'd0);

        // fill with rob 0 waiting on tag 8
        issue_ready = 1'b0;
        disp(4'd0, 4'd2, 8'h00, 1'b0, 16'h0008, 1'b1, 16'h0002);
        step();
        chk("fill0_valid", 32'(issue_valid), 32'd0);
        disp(4'd1, 4'd2, 8'h00, 1'b1, 16'h0010, 1'b1, 16'h0011);
        step();
        chk("fill1_rob", 32'(issue_rob_idx), 32'd1);
        chk("fill1_full", 32'(full), 32'd0);
        disp(4'd2, 4'd2, 8'h00, 1'b1, 16'h0020, 1'b1, 16'h0021);
        step();
        chk("fill2_full", 32'(full), 32'd0);
        disp(4'd3, 4'd2, 8'h00, 1'b1, 16'h0030, 1'b1, 16'h0031);
        step();
        chk("fill3_full", 32'(full), 32'd1);
        chk("fill3_rob", 32'(issue_rob_idx), 32'd1);

        // dispatch while full is dropped, only the removal happens
        issue_ready = 1'b1;
        disp(4'd5, 4'd2, 8'h00, 1'b1, 16'h0050, 1'b1, 16'h0051);
        step();
        chk("drop_full", 32'(full), 32'd0);
        chk("drop_rob", 32'(issue_rob_idx), 32'd2);
        // dispatch plus issue at count 3 keeps count 3
        disp(4'd7, 4'd2, 8'h00, 1'b1, 16'h0070, 1'b1, 16'h0071);
        step();
        chk("swap_full", 32'(full), 32'd0);
        chk("swap_rob", 32'(issue_rob_idx), 32'd3);
        issue_ready = 1'b0;
        disp(4'd9, 4'd2, 8'h00, 1'b1, 16'h0090, 1'b1, 16'h0091);
        step(); idle();
        chk("swap_count3_full", 32'(full), 32'd1);
        issue_ready = 1'b1;
        step();
        chk("order_rob7", 32'(issue_rob_idx), 32'd7);
        chk("order_rob7_a", 32'(issue_a), 32'h0070);
        chk("order_full", 32'(full), 32'd0);
        cdb(4'd8, 16'hCAFE);
        step(); idle();
        chk("order_rob0", 32'(issue_rob_idx), 32'd0);
        chk("order_rob0_a", 32'(issue_a), 32'hCAFE);
        chk("order_rob0_b", 32'(issue_b), 32'h0002);
        step();
        chk("order_rob9", 32'(issue_rob_idx), 32'd9);
        chk("order_rob9_b", 32'(issue_b), 32'h0091);
        step();
        chk("order_empty", 32'(issue_valid), 32'd0);

        // issue, dispatch and wakeup in one edge; shifted entry keeps woken value
        issue_ready = 1'b0;
        disp(4'd10, 4'd3, 8'h00, 1'b1, 16'h00A0, 1'b1, 16'h00A1);
        step();
        disp(4'd11, 4'd3, 8'h00, 1'b0, 16'h000C, 1'b1, 16'h00B1);
        step();
        issue_ready = 1'b1;
        disp(4'd13, 4'd3, 8'h00, 1'b1, 16'h00D0, 1'b1, 16'h00D1);
        cdb(4'd12, 16'h5555);
        step(); idle();
        chk("triple_rob", 32'(issue_rob_idx), 32'd11);
        chk("triple_a", 32'(issue_a), 32'h5555);
        chk("triple_b", 32'(issue_b), 32'h00B1);

        // flush with 3 entries and a concurrent dispatch
        issue_ready = 1'b0;
        disp(4'd14, 4'd3, 8'h00, 1'b1, 16'h00E0, 1'b1, 16'h00E1);
        step();
        chk("preflush_full", 32'(full), 32'd0);
        chk("preflush_valid", 32'(issue_valid), 32'd1);
        issue_ready = 1'b1;
        disp(4'd15, 4'd3, 8'h00, 1'b1, 16'h00F0, 1'b1, 16'h00F1);
        flush = 1'b1;
        step(); idle();
        chk("flush_valid", 32'(issue_valid), 32'd0);
        chk("flush_full", 32'(full), 32'd0);
        chk("flush_rob", 32'(issue_rob_idx), 32'd0);
        step();
        chk("flush_nodisp", 32'(issue_valid), 32'd0);

        // refill to full, then asynchronous reset between edges
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(4'(k + 1), 4'd4, 8'h00, 1'b1, 16'(k), 1'b1, 16'(k));
            step();
        end
        idle();
        chk("refill_full", 32'(full), 32'd1);
        chk("refill_rob", 32'(issue_rob_idx), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(issue_valid), 32'd0);
        chk("async_full", 32'(full), 32'd0);
        chk("async_a", 32'(issue_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_valid", 32'(issue_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fxu_reservation_station.md
# fxu_reservation_station

Receiving end of the dispatch interface for one fixed-point unit. It accepts one instruction per cycle from the instruction buffer together with operand values or ROB-tag owners, and drives `full` back to the dispatcher. It captures missing operands from the result broadcast bus. It issues the oldest entry whose operands are both ready to the FXU datapath, using a valid/ready handshake. One instance sits behind each of `fxu_0` and `fxu_1`.

## Interface
- `DEPTH`, 4: number of entries (2..8).
- `DW`, 16: operand/result width.
- `TW`, 4: ROB tag width (16-entry ROB).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `in_instr_valid` in 1: dispatch request.
- `in_rob_idx` in TW: destination ROB tag.
- `in_opcode` in 4: operation.
- `in_i` in 8: immediate.
- `in_a_valid`, `in_b_valid` in 1 each: operand value present.
- `in_a_value`, `in_b_value` in DW each: operand value; meaningful when the matching valid bit is 1.
- `in_a_owner`, `in_b_owner` in TW each: producing ROB tag; meaningful when the matching valid bit is 0.
- `full` out 1: no free entry; dispatcher must not send.
- `cdb_valid`, `cdb_tag` (TW), `cdb_value` (DW) in: result broadcast.
- `flush` in 1: synchronous discard of all entries.
- `issue_valid` out 1: an entry is presented to the FXU.
- `issue_ready` in 1: FXU accepts this cycle.
- `issue_rob_idx` (TW), `issue_opcode` (4), `issue_i` (8), `issue_a` (DW), `issue_b` (DW) out: fields of the issuing entry.

## Operation
- Each entry holds: busy, rob_idx, opcode, imm, a_rdy, a_val/a_tag, b_rdy, b_val/b_tag.
- Entries form a collapsing queue. Slot 0 is oldest and busy slots are contiguous from 0. `count` runs 0..DEPTH.
- `full = (count == DEPTH)`, decoded from registers only.
- Dispatch accepted iff `in_instr_valid & ~full & ~flush`. A dispatch arriving while `full` is dropped silently; it is a protocol violation of the dispatcher.
- Wakeup: for every busy entry, an operand with rdy=0 whose tag == `cdb_tag` while `cdb_valid` sets rdy=1 and val=`cdb_value`. Both operands may wake in the same cycle.
- Dispatch bypass: an incoming operand with valid=0 whose owner equals `cdb_tag` during `cdb_valid` is written with rdy=1 and the CDB value.
- Select: candidate = lowest-index busy entry with a_rdy & b_rdy. `issue_valid` = a candidate exists. The issue fields come from the candidate.
- `issue_valid` and the issue fields depend only on registered state, never on `issue_ready`.
- Removal: on `issue_valid & issue_ready`, the candidate slot k is removed. Slots k+1..count-1 shift down one, keeping their wakeup updates from the same cycle.
- Append: the new entry goes to slot `count` minus 1 if a removal occurs in the same cycle.
- Per-edge count update: count += accept − remove.
- `flush` takes priority over everything. Next state is all entries free and count=0, with no issue and no accept that cycle.
- Immediate-only opcodes (5, 6) arrive with both valids set by the dispatcher. The block does not special-case opcodes.

## Timing
- Reset (async assert): all busy=0, count=0, `full`=0, `issue_valid`=0, issue data buses 0.
- Reset deassert takes effect on the next edge.
- Dispatch at edge N with both operands ready → earliest `issue_valid` in cycle N+1 (1-cycle latency).
- CDB wakeup at edge N → entry is issuable in cycle N+1. There is no same-cycle CDB-to-issue forwarding.
- `full` rises in the cycle after the accept that fills the last slot. It falls in the cycle after a removal from a full queue, or immediately after a flush.
- Simultaneous issue and dispatch while `full`=1: the dispatch is rejected because `full` is already high; only the removal happens.
- Simultaneous issue, dispatch and wakeup: all three apply at the same edge. The shifted entries retain the woken value.
- Reset asserted mid-operation clears everything immediately, independent of `clk`.
- Tag compare is exact TW-bit equality; tags wrap mod 2^TW with no ordering implied.

## Test plan
- Reset and basic issue:
  - Stimulus: reset, then dispatch rob 3, op 0, a=0x0005 valid, b=0x0007 valid, with `issue_ready`=1.
  - Response: `issue_valid`=1 in the next cycle with rob 3, a=5, b=7. The entry is gone after that edge and `full` stays 0.
- Wakeup:
  - Stimulus: dispatch rob 4 with a valid=0, owner 2. Two cycles later drive cdb tag 2, value 0x1234.
  - Response: `issue_valid` first asserts the cycle after the broadcast, with `issue_a`=0x1234.
- Dispatch bypass:
  - Stimulus: dispatch b owner 9 while cdb tag 9, value 0xBEEF is on the bus in the same cycle.
  - Response: issue next cycle with `issue_b`=0xBEEF.
- Fill and order:
  - Stimulus: `issue_ready`=0; dispatch rob 0..3, where rob 0 waits on tag 8 and rob 1..3 are ready.
  - Response: `full`=1 after the 4th accept. With `issue_ready`=1, order is rob 1, 2, 3; after cdb tag 8, rob 0 issues. `full` drops after the first removal.
- Full plus simultaneous events:
  - Stimulus: while full, drive dispatch rob 5 and issue in the same cycle.
  - Response: rob 5 is not stored and count becomes 3.
  - Next stimulus: dispatch plus issue with count 3.
  - Response: count stays 3 and the new entry sits last.
- Flush and async reset:
  - Stimulus: flush with 3 entries plus a concurrent dispatch.
  - Response: count=0 and `issue_valid`=0 next cycle.
  - Stimulus: assert `rst_n`=0 between edges.
  - Response: `issue_valid` and `full` drop immediately.
